// File: rtl/morse_decoder.sv
// Morse straight-key decoder: synchronizes the key line, times marks and spaces in
// Morse units and emits one ASCII strobe per decoded letter or word gap.
module morse_decoder #(
  parameter int unsigned CLK_DIVIDER = 1_200_000,
  parameter int unsigned DASH_MIN    = 2,
  parameter int unsigned LETTER_GAP  = 3,
  parameter int unsigned WORD_GAP    = 7
) (
  input  logic       clk_24,
  input  logic       rst,
  input  logic       key_in,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_err,
  output logic       o_key
);

  localparam int unsigned PrescW = (CLK_DIVIDER > 1) ? $clog2(CLK_DIVIDER) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(CLK_DIVIDER - 1);
  // The edge cycle itself is count 0, so the next cycle resumes at 1.
  localparam logic [PrescW-1:0] PrescRestart = (CLK_DIVIDER > 1) ? PrescW'(1) : '0;
  localparam logic [2:0] DashMin    = 3'(DASH_MIN);
  localparam logic [2:0] LetterLast = 3'(LETTER_GAP - 1);
  localparam logic [2:0] WordLast   = 3'(WORD_GAP - 1);

  typedef enum logic [1:0] {StIdle, StMark, StSpace} state_e;

  state_e            state_q, state_d;
  logic              sync1_q, sync2_q, prev_q;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [2:0]        dur_q, dur_d;
  logic [6:0]        code_q, code_d;
  logic [2:0]        len_q, len_d;
  logic              ovf_q, ovf_d;
  logic              wp_q, wp_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              key_edge, key_rise, key_fall, tick;
  logic [7:0]        letter;

  function automatic logic [7:0] morse_lut(input logic [2:0] len, input logic [6:0] code);
    logic [7:0] ch;
    ch = 8'h00;
    case ({len, code})
      {3'd1, 7'd0}:  ch = "E";
      {3'd1, 7'd1}:  ch = "T";
      {3'd2, 7'd0}:  ch = "I";
      {3'd2, 7'd2}:  ch = "A";
      {3'd2, 7'd1}:  ch = "N";
      {3'd2, 7'd3}:  ch = "M";
      {3'd3, 7'd0}:  ch = "S";
      {3'd3, 7'd4}:  ch = "U";
      {3'd3, 7'd2}:  ch = "R";
      {3'd3, 7'd6}:  ch = "W";
      {3'd3, 7'd1}:  ch = "D";
      {3'd3, 7'd5}:  ch = "K";
      {3'd3, 7'd3}:  ch = "G";
      {3'd3, 7'd7}:  ch = "O";
      {3'd4, 7'd0}:  ch = "H";
      {3'd4, 7'd8}:  ch = "V";
      {3'd4, 7'd4}:  ch = "F";
      {3'd4, 7'd2}:  ch = "L";
      {3'd4, 7'd6}:  ch = "P";
      {3'd4, 7'd14}: ch = "J";
      {3'd4, 7'd1}:  ch = "B";
      {3'd4, 7'd9}:  ch = "X";
      {3'd4, 7'd5}:  ch = "C";
      {3'd4, 7'd13}: ch = "Y";
      {3'd4, 7'd3}:  ch = "Z";
      {3'd4, 7'd11}: ch = "Q";
      {3'd5, 7'd31}: ch = "0";
      {3'd5, 7'd30}: ch = "1";
      {3'd5, 7'd28}: ch = "2";
      {3'd5, 7'd24}: ch = "3";
      {3'd5, 7'd16}: ch = "4";
      {3'd5, 7'd0}:  ch = "5";
      {3'd5, 7'd1}:  ch = "6";
      {3'd5, 7'd3}:  ch = "7";
      {3'd5, 7'd7}:  ch = "8";
      {3'd5, 7'd15}: ch = "9";
      default:       ch = 8'h00;
    endcase
    return ch;
  endfunction

  always_comb begin
    key_edge = sync2_q ^ prev_q;
    key_rise = sync2_q & ~prev_q;
    key_fall = ~sync2_q & prev_q;
    tick     = ~key_edge & (presc_q == PrescLast);
    presc_d  = key_edge ? PrescRestart : (tick ? '0 : presc_q + 1'b1);
    if (key_edge)                 dur_d = 3'd0;
    else if (tick && dur_q != 3'd7) dur_d = dur_q + 3'd1;
    else                          dur_d = dur_q;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    wp_d    = wp_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    letter  = morse_lut(len_q, code_q);
    case (state_q)
      StIdle: if (key_rise) state_d = StMark;
      StMark: begin
        if (key_fall) begin
          if (dur_q != 3'd0) begin
            if (len_q == 3'd7) begin
              ovf_d = 1'b1;
            end else begin
              code_d = code_q | (7'(dur_q >= DashMin) << len_q);
              len_d  = len_q + 3'd1;
            end
          end
          state_d = (len_d != 3'd0 || wp_q) ? StSpace : StIdle;
        end
      end
      StSpace: begin
        if (key_rise) begin
          state_d = StMark;
        end else if (tick) begin
          if (dur_q == LetterLast && (len_q != 3'd0 || ovf_q)) begin
            valid_d = 1'b1;
            err_d   = ovf_q || (letter == 8'h00);
            data_d  = err_d ? "?" : letter;
            code_d  = 7'd0;
            len_d   = 3'd0;
            ovf_d   = 1'b0;
            wp_d    = 1'b1;
          end else if (dur_q == WordLast && wp_q) begin
            valid_d = 1'b1;
            data_d  = " ";
            wp_d    = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_24 or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      presc_q <= '0;
      dur_q   <= 3'd0;
      code_q  <= 7'd0;
      len_q   <= 3'd0;
      ovf_q   <= 1'b0;
      wp_q    <= 1'b0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      presc_q <= presc_d;
      dur_q   <= dur_d;
      code_q  <= code_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      wp_q    <= wp_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_err   = err_q;
  assign o_key   = sync2_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: a timing/ITU-table model checked every cycle, plus
// literal expectations for the decoded character stream of each keyed pattern.
module tb_morse_decoder;

  localparam int unsigned Cd        = 4;
  localparam int unsigned DashMin   = 2;
  localparam int unsigned LetterGap = 3;
  localparam int unsigned WordGap   = 7;
  localparam int PhIdle  = 0;
  localparam int PhMark  = 1;
  localparam int PhSpace = 2;

  logic       clk_24 = 1'b0;
  logic       rst;
  logic       key_in;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_err;
  logic       o_key;

  morse_decoder #(.CLK_DIVIDER(Cd)) dut (
    .clk_24  (clk_24),
    .rst     (rst),
    .key_in  (key_in),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_err   (o_err),
    .o_key   (o_key)
  );

  always #5 clk_24 = ~clk_24;

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    first_vcyc = -1;
  int    t_drive;
  logic  samp;
  string got_s = "";
  string gerr_s = "";

  string pats [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                       "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                       "..-", "...-", ".--", "-..-", "-.--", "--..", "-----", ".----", "..---",
                       "...--", "....-", ".....", "-....", "--...", "---..", "----."};
  string syms = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

  // Model state: phase, cycles since the last synchronized edge, keyed symbols.
  int         ph = PhIdle;
  int         n = 0;
  string      sym = "";
  bit         ovf = 1'b0;
  bit         wp = 1'b0;
  logic       lv = 1'b0;
  logic       samp_prev = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_err = 1'b0;

  function void chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function void chk_str(string name, string act, string exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] decode(string p);
    for (int i = 0; i < 36; i++) begin
      if (pats[i] == p) return syms[i];
    end
    return 8'h00;
  endfunction

  always @(posedge clk_24) cyc <= cyc + 1;

  always @(posedge clk_24 or posedge rst) begin
    if (rst) samp <= 1'b0;
    else     samp <= key_in;
  end

  always @(negedge clk_24) begin : cmp
    logic       lvl;
    int         units;
    logic [7:0] ch;
    string      s1;
    if (rst) begin
      chk("rst_o_valid", o_valid, 0);
      chk("rst_o_err", o_err, 0);
      chk("rst_o_data", o_data, 0);
      chk("rst_o_key", o_key, 0);
      ph = PhIdle; n = 0; sym = ""; ovf = 1'b0; wp = 1'b0; lv = 1'b0; samp_prev = 1'b0;
      exp_data = 8'h00; exp_valid = 1'b0; exp_err = 1'b0;
    end else begin
      lvl = samp_prev;
      samp_prev = samp;
      chk("o_key", o_key, lvl);
      chk("o_valid", o_valid, exp_valid);
      chk("o_err", o_err, exp_err);
      chk("o_data", o_data, exp_data);
      if (o_valid) begin
        got_s  = $sformatf("%s%c", got_s, o_data);
        gerr_s = $sformatf("%s%0d", gerr_s, o_err);
        if (first_vcyc < 0) first_vcyc = cyc;
      end
      // Advance the model to predict the outputs of the next cycle.
      n = n + 1;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (lvl != lv) begin
        if (lvl) begin
          ph = PhMark;
        end else begin
          units = n / Cd;
          if (units > 7) units = 7;
          if (units > 0) begin
            if (sym.len() == 7) begin
              ovf = 1'b1;
            end else begin
              s1 = (units >= DashMin) ? "-" : ".";
              sym = {sym, s1};
            end
          end
          ph = (sym.len() > 0 || wp) ? PhSpace : PhIdle;
        end
        n = 0;
      end else if (ph == PhSpace) begin
        if (n == LetterGap * Cd - 1 && (sym.len() > 0 || ovf)) begin
          ch = ovf ? 8'h00 : decode(sym);
          exp_valid = 1'b1;
          exp_err   = (ch == 8'h00);
          exp_data  = exp_err ? 8'h3F : ch;
          sym = "";
          ovf = 1'b0;
          wp  = 1'b1;
        end else if (n == WordGap * Cd - 1 && wp) begin
          exp_valid = 1'b1;
          exp_data  = 8'h20;
          wp = 1'b0;
          ph = PhIdle;
        end
      end
      lv = lvl;
    end
  end

  // Called just after a rising edge; v is sampled on the next cyc_n rising edges.
  task automatic hold(input logic v, input int cyc_n);
    key_in = v;
    repeat (cyc_n) begin
      @(posedge clk_24);
      #2;
    end
  endtask

  task automatic send(input string p);
    for (int i = 0; i < p.len(); i++) begin
      hold(1'b1, (p[i] == 8'h2D) ? 3 * Cd : Cd);
      if (i != p.len() - 1) hold(1'b0, Cd);
    end
  endtask

  task automatic expect_out(input string name, input string chars, input string errs);
    chk_str({name, "_chars"}, got_s, chars);
    chk_str({name, "_errs"}, gerr_s, errs);
    got_s  = "";
    gerr_s = "";
  endtask

  initial begin
    rst    = 1'b1;
    key_in = 1'b0;
    repeat (3) @(posedge clk_24);
    #2;
    rst = 1'b0;
    hold(1'b0, 2);
    chk("reset_o_data", o_data, 8'h00);
    chk("reset_o_valid", o_valid, 0);
    chk("reset_o_err", o_err, 0);
    chk("reset_o_key", o_key, 0);

    // Single dot: 'E' then the word-gap space.
    hold(1'b1, 4);
    t_drive = cyc;
    first_vcyc = -1;
    hold(1'b0, 40);
    chk("e_latency", first_vcyc - t_drive, 14);
    expect_out("e", "E ", "00");

    hold(1'b1, 4); hold(1'b0, 4); hold(1'b1, 12); hold(1'b0, 40);
    expect_out("a", "A ", "00");

    hold(1'b1, 12); hold(1'b0, 40);
    expect_out("t", "T ", "00");

    repeat (8) begin
      hold(1'b1, 4);
      hold(1'b0, 4);
    end
    hold(1'b0, 40);
    expect_out("overflow", "? ", "10");

    send(".-.-.-"); hold(1'b0, 40);
    expect_out("unmapped", "? ", "10");

    hold(1'b1, 1); hold(1'b0, 40);
    expect_out("glitch", "", "");

    // 7 cycles is one unit (dot), 8 cycles is two units (dash).
    hold(1'b1, 7); hold(1'b0, 4); hold(1'b1, 8); hold(1'b0, 40);
    expect_out("dash_min", "A ", "00");

    hold(1'b1, 4); hold(1'b0, 11); hold(1'b1, 4); hold(1'b0, 40);
    expect_out("gap_short", "I ", "00");

    hold(1'b1, 4); hold(1'b0, 12); hold(1'b1, 4); hold(1'b0, 40);
    expect_out("gap_exact", "EE ", "000");

    send("-.-"); hold(1'b0, 12); send("----."); hold(1'b0, 28);
    send("--.-"); hold(1'b0, 12); send("-----"); hold(1'b0, 40);
    expect_out("words", "K9 Q0 ", "000000");

    // Reset during the space of a partial letter.
    hold(1'b1, 4); hold(1'b0, 5);
    rst = 1'b1;
    hold(1'b0, 2);
    rst = 1'b0;
    hold(1'b0, 40);
    expect_out("rst_mid", "", "");
    chk("rst_mid_o_data", o_data, 8'h00);
    chk("rst_mid_o_valid", o_valid, 0);
    chk("rst_mid_o_err", o_err, 0);
    chk("rst_mid_o_key", o_key, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 Parameter CLK_DIVIDER, default 1_200_000, is the number of clk_24 cycles per Morse unit (50 ms at 24 MHz).
REQ-002 Parameter DASH_MIN, default 2, is the minimum mark length in units that classifies as a dash.
REQ-003 Parameter LETTER_GAP, default 3, is the space length in units that terminates a letter.
REQ-004 Parameter WORD_GAP, default 7, is the space length in units that terminates a word; legal range is LETTER_GAP+1..7.
REQ-005 clk_24  input  1  sole clock; one clock; reset is asynchronous and active-high.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 key_in  input  1  asynchronous Morse key line; high means tone/mark.
REQ-008 o_data  output  8  decoded ASCII character.
REQ-009 o_valid  output  1  one-cycle strobe qualifying o_data; no backpressure, suitable for txuart i_wr.
REQ-010 o_err  output  1  one-cycle strobe coincident with o_valid when o_data is 0x3F because of an unknown code or overflow.
REQ-011 o_key  output  1  synchronized key level for LED display.

Function
REQ-012 key_in SHALL pass through a 2-flop synchronizer; all timing uses the synchronized level, and o_key equals it.
REQ-013 A prescaler SHALL count 0..CLK_DIVIDER-1 and emit a one-cycle tick on the terminal count; it SHALL be cleared to 0 on every synchronized key edge, and the edge takes priority over a coincident tick.
REQ-014 A 3-bit duration counter SHALL increment on each tick, saturate at 7, and clear to 0 on every key edge.
REQ-015 The symbol store SHALL hold code[6:0] (bit i = symbol i, 1 = dash, first symbol in bit 0) and len[2:0], plus an overflow flag and a word-pending flag.
REQ-016 State IDLE: key rising edge -> MARK.
REQ-017 State MARK: on the falling edge, dur==0 -> discard as glitch; dur<DASH_MIN -> append dot; otherwise -> append dash; then go to SPACE if len>0 or word-pending, else IDLE.
REQ-018 Appending when len==7 SHALL set overflow and leave code/len unchanged.
REQ-019 State SPACE: a tick making dur equal LETTER_GAP with len>0 or overflow set SHALL emit a letter, clear code/len/overflow, set word-pending, and stay in SPACE.
REQ-020 State SPACE: a tick making dur equal WORD_GAP with word-pending set SHALL emit 0x20, clear word-pending, and go to IDLE.
REQ-021 State SPACE: a key rising edge -> MARK; the pending letter continues if it has not been emitted yet.
REQ-022 Letter emission SHALL map {len,code} to uppercase A-Z (0x41-0x5A) and 0-9 (0x30-0x39) per ITU Morse, using the same code/len encoding as ascii_2_morse.
REQ-023 Any unmapped code or overflow SHALL emit 0x3F with o_err=1.
REQ-024 o_valid SHALL be registered and high for exactly one clk_24 cycle, in the cycle after the emitting tick; o_data SHALL hold its value until the next emission.
REQ-025 At most one emission SHALL occur per tick; no output SHALL be produced in IDLE.

Reset
REQ-026 rst high SHALL asynchronously force state IDLE and clear the synchronizer, prescaler, dur, code, len, overflow, word-pending, o_data=0x00, o_valid=0, o_err=0, o_key=0.
REQ-027 Reset mid-letter SHALL discard all partial symbols; no character is emitted after release until a new complete letter is keyed.

Verification (CLK_DIVIDER=4, other parameters at defaults)
REQ-028 Mark 4 cycles, then low -> o_valid=1, o_data=0x45 ('E'), o_err=0, 3 ticks after the falling edge.
REQ-029 Mark 4 cycles, space 4 cycles, mark 12 cycles, then low -> o_data=0x41 ('A').
REQ-030 'T' (mark 12 cycles), then low for 28+ cycles -> 0x54 followed by 0x20, then IDLE.
REQ-031 8 dots separated by 1-unit spaces -> o_data=0x3F with o_err=1; code '.-.-.-' (len 6, unmapped) -> 0x3F with o_err=1.
REQ-032 1-cycle high pulse on key_in from IDLE -> no o_valid at any time.
REQ-033 One dot, then rst pulsed during the space, then idle 40 cycles -> o_valid stays 0 and all outputs are at reset values.
